// File: rtl/rob_nway_squash.sv
// N-wide reorder buffer with wrap-bit pointers, per-entry valid bits, multi-CDB
// writeback, full flush and partial squash of entries younger than a branch.
package rob_nway_squash_pkg;
   localparam int ROB_ID_W = 4;

   typedef struct packed {
      logic        ready;
      logic [4:0]  rd_addr;
      logic [31:0] pc;
      logic [31:0] monitor_rd_wdata;
      logic [31:0] monitor_rs1_rdata;
      logic [31:0] monitor_rs2_rdata;
      logic [3:0]  monitor_mem_rmask;
      logic [31:0] monitor_mem_rdata;
      logic [31:0] monitor_mem_addr;
   } rob_entry_t;

   typedef struct packed {
      logic                ready;
      logic [ROB_ID_W-1:0] rob_id;
      logic [31:0]         result;
      logic [31:0]         monitor_rs1_rdata;
      logic [31:0]         monitor_rs2_rdata;
      logic [3:0]          monitor_mem_rmask;
      logic [31:0]         monitor_mem_rdata;
      logic [31:0]         monitor_mem_addr;
   } cdb_t;
endpackage

module rob_nway_squash
   import rob_nway_squash_pkg::*;
#(
   parameter int DEPTH_BITS = 4,
   parameter int NSIZE      = 2,
   parameter int CDB_COUNT  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  rob_entry_t            din [NSIZE],
   input  logic [NSIZE-1:0]      enqueue,
   output logic [DEPTH_BITS-1:0] rob_id_to_insert [NSIZE],
   output logic [DEPTH_BITS:0]   freespace,
   output logic [DEPTH_BITS:0]   elemcount,
   input  cdb_t                  cdb [CDB_COUNT],
   output rob_entry_t            dout [NSIZE],
   output logic [NSIZE-1:0]      commit_valid,
   input  logic [NSIZE-1:0]      dequeue,
   output logic [DEPTH_BITS-1:0] head_rob_id,
   input  logic                  flush_all,
   input  logic                  squash,
   input  logic [DEPTH_BITS-1:0] squash_rob_id
);
   localparam int DEPTH = 2**DEPTH_BITS;

   typedef logic [DEPTH_BITS:0]   ptr_t;
   typedef logic [DEPTH_BITS-1:0] idx_t;

   rob_entry_t       mem [DEPTH];
   logic [DEPTH-1:0] valid, valid_n, keep;
   ptr_t             alloc_ptr, commit_ptr, alloc_n, commit_n;
   ptr_t             enq_cnt, deq_cnt;
   idx_t             head_idx, sq_dist;
   idx_t             alloc_idx [NSIZE];
   idx_t             rd_idx [NSIZE];
   idx_t             cdb_idx [CDB_COUNT];
   rob_entry_t       alloc_entry [NSIZE];
   rob_entry_t       wb_entry [CDB_COUNT];
   logic [NSIZE-1:0] lane_ok, alloc_we;
   logic [CDB_COUNT-1:0] cdb_we;

   function automatic logic is_prefix(input logic [NSIZE-1:0] v);
      return (v & (v + NSIZE'(1))) == '0;
   endfunction

   assign head_idx    = commit_ptr[DEPTH_BITS-1:0];
   assign head_rob_id = head_idx;
   assign elemcount   = alloc_ptr - commit_ptr;
   assign freespace   = ptr_t'(DEPTH) - elemcount;
   // distance from the head to the youngest survivor of a squash
   assign sq_dist     = squash_rob_id - head_idx;

   for (genvar j = 0; j < NSIZE; j++) begin : g_lane
      assign alloc_idx[j]        = alloc_ptr[DEPTH_BITS-1:0] + idx_t'(j);
      assign rob_id_to_insert[j] = alloc_idx[j];
      assign rd_idx[j]           = head_idx + idx_t'(j);
      assign alloc_we[j]         = !rst && !flush_all && !squash && enqueue[j];
      assign lane_ok[j]          = (ptr_t'(j) < elemcount) && valid[rd_idx[j]] && mem[rd_idx[j]].ready;

      always_comb begin
         alloc_entry[j]       = din[j];
         alloc_entry[j].ready = 1'b0;
         dout[j]              = mem[rd_idx[j]];
         dout[j].ready        = mem[rd_idx[j]].ready & valid[rd_idx[j]];
      end
   end

   for (genvar k = 0; k < CDB_COUNT; k++) begin : g_cdb
      assign cdb_idx[k] = idx_t'(cdb[k].rob_id);
      assign cdb_we[k]  = !rst && !flush_all && cdb[k].ready && valid[cdb_idx[k]]
                          && (!squash || keep[cdb_idx[k]]);

      always_comb begin
         wb_entry[k]                   = mem[cdb_idx[k]];
         wb_entry[k].ready             = 1'b1;
         wb_entry[k].monitor_rd_wdata  = cdb[k].result;
         wb_entry[k].monitor_rs1_rdata = cdb[k].monitor_rs1_rdata;
         wb_entry[k].monitor_rs2_rdata = cdb[k].monitor_rs2_rdata;
         wb_entry[k].monitor_mem_rmask = cdb[k].monitor_mem_rmask;
         wb_entry[k].monitor_mem_rdata = cdb[k].monitor_mem_rdata;
         wb_entry[k].monitor_mem_addr  = cdb[k].monitor_mem_addr;
      end
   end

   always_comb begin
      logic run;
      run          = 1'b1;
      commit_valid = '0;
      for (int j = 0; j < NSIZE; j++) begin
         run             = run & lane_ok[j];
         commit_valid[j] = run;
      end
   end

   always_comb begin
      enq_cnt = '0;
      deq_cnt = '0;
      for (int j = 0; j < NSIZE; j++) begin
         enq_cnt = enq_cnt + ptr_t'(enqueue[j]);
         deq_cnt = deq_cnt + ptr_t'(dequeue[j]);
      end
   end

   always_comb begin
      keep = '0;
      for (int i = 0; i < DEPTH; i++) keep[i] = (idx_t'(i) - head_idx) <= sq_dist;
   end

   // valid tracks occupancy exactly, so masking by offset from head is enough
   always_comb begin
      valid_n  = valid;
      alloc_n  = alloc_ptr + enq_cnt;
      commit_n = commit_ptr + deq_cnt;
      if (flush_all) begin
         valid_n  = '0;
         alloc_n  = commit_ptr;
         commit_n = commit_ptr;
      end else begin
         if (squash) begin
            valid_n = valid_n & keep;
            alloc_n = commit_ptr + ptr_t'(sq_dist) + ptr_t'(1);
         end
         for (int j = 0; j < NSIZE; j++)
            if (dequeue[j]) valid_n[rd_idx[j]] = 1'b0;
         for (int j = 0; j < NSIZE; j++)
            if (alloc_we[j]) valid_n[alloc_idx[j]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alloc_ptr  <= '0;
         commit_ptr <= '0;
         valid      <= '0;
      end else begin
         alloc_ptr  <= alloc_n;
         commit_ptr <= commit_n;
         valid      <= valid_n;
      end
   end

   // later writes win: higher CDB channel, then allocation
   always_ff @(posedge clk) begin
      for (int k = 0; k < CDB_COUNT; k++)
         if (cdb_we[k]) mem[cdb_idx[k]] <= wb_entry[k];
      for (int j = 0; j < NSIZE; j++)
         if (alloc_we[j]) mem[alloc_idx[j]] <= alloc_entry[j];
   end

   a_enq_room: assert property (@(posedge clk) disable iff (rst)
      (!flush_all && !squash) |-> (enq_cnt <= freespace + deq_cnt))
      else $error("enqueue exceeds free space");
   a_enq_prefix: assert property (@(posedge clk) disable iff (rst) is_prefix(enqueue))
      else $error("enqueue is not a contiguous low prefix");
   a_deq_legal: assert property (@(posedge clk) disable iff (rst)
      !flush_all |-> (is_prefix(dequeue) && ((dequeue & ~commit_valid) == '0)))
      else $error("dequeue without commit_valid");
   a_squash_live: assert property (@(posedge clk) disable iff (rst)
      (squash && !flush_all) |-> (ptr_t'(sq_dist) < elemcount))
      else $error("squash_rob_id not occupied");
endmodule
